kuuga_bram_mux: RTL and testbench

//   N-channel arbiter and bridge from core-side req/gnt/rvalid memory ports onto one single-port block RAM.
//   - Converts byte addresses to word addresses.
//   - Tracks in-flight accesses through the BRAM's fixed read latency.
//   - Flags accesses outside the mapped window.

---
 rtl/kuuga_mem_pkg.sv | 20 ++
 rtl/kuuga_rr_arbiter.sv | 32 +++
 rtl/kuuga_bram_mux.sv | 125 ++++++++++++
 tb/tb_kuuga_bram_mux.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kuuga_mem_pkg.sv
// Shared types and helpers for the Kuuga BRAM mux and its round-robin arbiter.
package kuuga_mem_pkg;

  localparam int MAX_CH         = 8;
  localparam int BYTES_PER_WORD = 4;

  // Index width that never collapses to zero bits, so a single channel still has an ID field.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int CH_ID_W = clog2_min1(MAX_CH);

  typedef struct packed {
    logic               valid;
    logic [CH_ID_W-1:0] ch_id;
    logic               err;
  } mem_rsp_t;

endpackage

// File: rtl/kuuga_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and the first requester wins.
// Zero latency and stateless; the caller owns and advances the pointer.
module kuuga_rr_arbiter
  import kuuga_mem_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % N);
      if (!vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kuuga_bram_mux.sv
// Round-robin bridge from N req/gnt/rvalid ports onto one single-port BRAM; grant in the request cycle.
// Responses arrive exactly READ_LATENCY cycles after the grant, one per cycle, with no backpressure.
module kuuga_bram_mux
  import kuuga_mem_pkg::*;
#(
  parameter int                    NUM_CH         = 2,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 8 * BYTES_PER_WORD,
  parameter int                    MEM_ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    READ_LATENCY   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              ch_req_i,
  output logic [NUM_CH-1:0]              ch_gnt_o,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_addr_i,
  input  logic [NUM_CH-1:0]              ch_we_i,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] ch_be_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_wdata_i,
  output logic [NUM_CH-1:0]              ch_rvalid_o,
  output logic [NUM_CH*DATA_WIDTH-1:0]   ch_rdata_o,
  output logic [NUM_CH-1:0]              ch_err_o,
  output logic                           mem_en_o,
  output logic [DATA_WIDTH/8-1:0]        mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0]          mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]          mem_rdata_i
);

  localparam int BPW    = DATA_WIDTH / 8;
  localparam int OFF_SH = (BPW > 1) ? $clog2(BPW) : 0;
  localparam int IDX_W  = clog2_min1(NUM_CH);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("kuuga_bram_mux: READ_LATENCY must be 1..4");
  end
  if (DATA_WIDTH < 8 || DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("kuuga_bram_mux: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
    $error("kuuga_bram_mux: NUM_CH must be 1..8");
  end

  logic [NUM_CH-1:0]     arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_vld;
  logic                  gnt_vld;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] sel_addr, off, word_full;
  logic                  in_win;

  kuuga_rr_arbiter #(.N(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .req_i (ch_req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  // Grants are suppressed while reset is held so nothing reaches the BRAM or the pipeline.
  assign gnt_vld  = arb_vld & rst_n;
  assign ch_gnt_o = arb_gnt & {NUM_CH{rst_n}};

  assign sel_addr  = ch_addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign off       = sel_addr - BASE_ADDR;
  assign word_full = off >> OFF_SH;
  assign in_win    = (sel_addr >= BASE_ADDR) && ((word_full >> MEM_ADDR_WIDTH) == '0);

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt_vld && in_win) begin
      mem_en_o    = 1'b1;
      mem_we_o    = ch_we_i[arb_idx] ? ch_be_i[arb_idx*BPW +: BPW] : '0;
      mem_addr_o  = word_full[MEM_ADDR_WIDTH-1:0];
      mem_wdata_o = ch_wdata_i[arb_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rr_ptr_d = !gnt_vld                         ? rr_ptr_q :
                    (arb_idx == IDX_W'(NUM_CH - 1))  ? '0       :
                                                       arb_idx + 1'b1;

  mem_rsp_t rsp_q [READ_LATENCY];
  mem_rsp_t rsp_d0;
  mem_rsp_t rsp_last;

  assign rsp_d0 = '{valid: gnt_vld, ch_id: CH_ID_W'(arb_idx), err: !in_win};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        rsp_q[s] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rsp_q[0] <= rsp_d0;
      for (int s = 1; s < READ_LATENCY; s++) begin
        rsp_q[s] <= rsp_q[s-1];
      end
    end
  end

  assign rsp_last = rsp_q[READ_LATENCY-1];

  always_comb begin
    ch_rvalid_o = '0;
    ch_err_o    = '0;
    ch_rdata_o  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rsp_last.valid && rsp_last.ch_id == CH_ID_W'(k)) begin
        ch_rvalid_o[k] = 1'b1;
        ch_err_o[k]    = rsp_last.err;
        if (!rsp_last.err) begin
          ch_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_rdata_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_kuuga_bram_mux.sv
// Bench for kuuga_bram_mux: a 2-channel instance on a byte-writable memory and two 3-channel instances (latency 3 and 1).
module tb_kuuga_bram_mux;
  localparam int          RLA    = 2;
  localparam int          RLB    = 3;
  localparam int          RLC    = 1;
  localparam logic [31:0] BASE_B = 32'h100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  a_req, a_we, a_gnt, a_rv, a_err;
  logic [63:0] a_addr, a_wd, a_rd;
  logic [7:0]  a_be;
  logic        a_men;
  logic [3:0]  a_mwe;
  logic [15:0] a_maddr;
  logic [31:0] a_mwd, a_mrd;

  logic [2:0]  b_req, b_we, b_gnt, b_rv, b_err, c_gnt, c_rv, c_err;
  logic [95:0] b_addr, b_wd, b_rd, c_rd;
  logic [11:0] b_be;
  logic        b_men, c_men;
  logic [3:0]  b_mwe, c_mwe;
  logic [5:0]  b_maddr, c_maddr;
  logic [31:0] b_mwd, c_mwd, b_mrd, c_mrd;

  kuuga_bram_mux #(.NUM_CH(2), .MEM_ADDR_WIDTH(16), .BASE_ADDR(32'h0), .READ_LATENCY(RLA)) u_a (
    .clk(clk), .rst_n(rst_n), .ch_req_i(a_req), .ch_gnt_o(a_gnt), .ch_addr_i(a_addr),
    .ch_we_i(a_we), .ch_be_i(a_be), .ch_wdata_i(a_wd), .ch_rvalid_o(a_rv), .ch_rdata_o(a_rd),
    .ch_err_o(a_err), .mem_en_o(a_men), .mem_we_o(a_mwe), .mem_addr_o(a_maddr),
    .mem_wdata_o(a_mwd), .mem_rdata_i(a_mrd));

  kuuga_bram_mux #(.NUM_CH(3), .MEM_ADDR_WIDTH(6), .BASE_ADDR(BASE_B), .READ_LATENCY(RLB)) u_b (
    .clk(clk), .rst_n(rst_n), .ch_req_i(b_req), .ch_gnt_o(b_gnt), .ch_addr_i(b_addr),
    .ch_we_i(b_we), .ch_be_i(b_be), .ch_wdata_i(b_wd), .ch_rvalid_o(b_rv), .ch_rdata_o(b_rd),
    .ch_err_o(b_err), .mem_en_o(b_men), .mem_we_o(b_mwe), .mem_addr_o(b_maddr),
    .mem_wdata_o(b_mwd), .mem_rdata_i(b_mrd));

  kuuga_bram_mux #(.NUM_CH(3), .MEM_ADDR_WIDTH(6), .BASE_ADDR(BASE_B), .READ_LATENCY(RLC)) u_c (
    .clk(clk), .rst_n(rst_n), .ch_req_i(b_req), .ch_gnt_o(c_gnt), .ch_addr_i(b_addr),
    .ch_we_i(b_we), .ch_be_i(b_be), .ch_wdata_i(b_wd), .ch_rvalid_o(c_rv), .ch_rdata_o(c_rd),
    .ch_err_o(c_err), .mem_en_o(c_men), .mem_we_o(c_mwe), .mem_addr_o(c_maddr),
    .mem_wdata_o(c_mwd), .mem_rdata_i(c_mrd));

  // Read-first byte-writable memory behind instance A.
  logic [31:0] bram_a [65536];
  logic [31:0] a_pipe [RLA];
  always @(posedge clk) begin
    if (a_men) begin
      a_pipe[0] <= bram_a[a_maddr];
      for (int b = 0; b < 4; b++) if (a_mwe[b]) bram_a[a_maddr][b*8 +: 8] <= a_mwd[b*8 +: 8];
    end
    for (int s = 1; s < RLA; s++) a_pipe[s] <= a_pipe[s-1];
  end
  assign a_mrd = a_pipe[RLA-1];

  // Instances B and C see a memory whose data is a tag plus the presented word address.
  logic [31:0] b_pipe [RLB];
  logic [31:0] c_pipe;
  always @(posedge clk) begin
    b_pipe[0] <= {16'hB0B0, 10'h0, b_maddr};
    for (int s = 1; s < RLB; s++) b_pipe[s] <= b_pipe[s-1];
    c_pipe <= {16'hC0C0, 10'h0, c_maddr};
  end
  assign b_mrd = b_pipe[RLB-1];
  assign c_mrd = c_pipe;

  typedef struct { int ch; bit err; bit rd; logic [31:0] data; } exp_t;
  exp_t        ea [int];
  exp_t        eb [int];
  exp_t        ec [int];
  logic [31:0] ref_mem [int];

  bit          pend [3];
  logic [31:0] p_addr [3];
  bit          p_we [3];
  logic [3:0]  p_be [3];
  logic [31:0] p_wd [3];
  int cyc = 0, ptr_a = 0, ptr_b = 0, checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic put(input int k, input logic [31:0] addr, input bit we, input logic [3:0] be, input logic [31:0] wd);
    pend[k] = 1'b1; p_addr[k] = addr; p_we[k] = we; p_be[k] = be; p_wd[k] = wd;
  endtask

  task automatic pack(input int n);
    a_req = '0; a_we = '0; a_be = '0; a_addr = '0; a_wd = '0;
    b_req = '0; b_we = '0; b_be = '0; b_addr = '0; b_wd = '0;
    for (int k = 0; k < n; k++) begin
      if (n == 2) begin
        a_req[k] = pend[k]; a_we[k] = p_we[k]; a_be[k*4 +: 4] = p_be[k];
        a_addr[k*32 +: 32] = p_addr[k]; a_wd[k*32 +: 32] = p_wd[k];
      end else begin
        b_req[k] = pend[k]; b_we[k] = p_we[k]; b_be[k*4 +: 4] = p_be[k];
        b_addr[k*32 +: 32] = p_addr[k]; b_wd[k*32 +: 32] = p_wd[k];
      end
    end
  endtask

  function automatic bit in_win(input logic [31:0] addr, input logic [31:0] base, input int maw);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && (64'(off >> 2) < (64'd1 << maw));
  endfunction

  task automatic chk_mem(input string t, input logic [2:0] g, input logic en, input logic [31:0] ad,
                         input logic [3:0] we, input logic [31:0] wd, input logic [2:0] eg,
                         input logic een, input logic [31:0] ead, input logic [3:0] ewe, input logic [31:0] ewd);
    chk({t, "_gnt"}, g, eg);
    chk({t, "_mem_en"}, en, een);
    chk({t, "_mem_addr"}, ad, ead);
    chk({t, "_mem_we"}, we, ewe);
    chk({t, "_mem_wdata"}, wd, ewd);
  endtask

  task automatic chk_rsp(input string t, input bit hit, input exp_t e, input logic [2:0] rv,
                         input logic [2:0] er, input logic [95:0] rd);
    logic [2:0]  erv, eer;
    logic [95:0] erd, msk;
    erv = '0; eer = '0; erd = '0; msk = '1;
    if (hit) begin
      erv[e.ch] = 1'b1;
      eer[e.ch] = e.err;
      if (!e.err && e.rd) erd[e.ch*32 +: 32] = e.data;
      else if (!e.err) msk[e.ch*32 +: 32] = '0;
    end
    chk({t, "_rvalid"}, rv, erv);
    chk({t, "_err"}, er, eer);
    chk({t, "_rdata"}, rd & msk, erd & msk);
  endtask

  // One cycle: drive pending requests, predict grant and memory drive, log the response, check due responses.
  task automatic step(input int n);
    int          w, maw, c;
    bit          win, hit;
    logic [31:0] base, word, ewd, m;
    logic [3:0]  ewe;
    logic [2:0]  eg;
    exp_t        e;
    pack(n);
    #1;
    maw  = (n == 2) ? 16 : 6;
    base = (n == 2) ? 32'h0 : BASE_B;
    w = -1;
    for (int i = 0; i < n; i++) begin
      c = ((n == 2 ? ptr_a : ptr_b) + i) % n;
      if (w < 0 && pend[c]) w = c;
    end
    eg = '0; win = 1'b0; word = '0; ewe = '0; ewd = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      win   = in_win(p_addr[w], base, maw);
      word  = (p_addr[w] - base) >> 2;
      ewe   = (win && p_we[w]) ? p_be[w] : 4'h0;
      ewd   = win ? p_wd[w] : 32'h0;
    end
    if (n == 2) begin
      chk_mem("a", {1'b0, a_gnt}, a_men, 32'(a_maddr), a_mwe, a_mwd, eg, win, win ? word : 0, ewe, ewd);
    end else begin
      chk_mem("b", b_gnt, b_men, 32'(b_maddr), b_mwe, b_mwd, eg, win, win ? word : 0, ewe, ewd);
      chk_mem("c", c_gnt, c_men, 32'(c_maddr), c_mwe, c_mwd, eg, win, win ? word : 0, ewe, ewd);
    end
    if (w >= 0) begin
      e.ch = w; e.err = !win; e.rd = 1'b0; e.data = '0;
      if (n == 2) begin
        if (win && !p_we[w] && ref_mem.exists(int'(word))) begin
          e.rd = 1'b1; e.data = ref_mem[int'(word)];
        end
        if (win && p_we[w]) begin
          if (ref_mem.exists(int'(word)) || p_be[w] == 4'hF) begin
            m = ref_mem.exists(int'(word)) ? ref_mem[int'(word)] : 32'h0;
            for (int b = 0; b < 4; b++) if (p_be[w][b]) m[b*8 +: 8] = p_wd[w][b*8 +: 8];
            ref_mem[int'(word)] = m;
          end
        end
        ea[cyc + RLA] = e;
        ptr_a = (w + 1) % 2;
      end else begin
        e.rd   = win && !p_we[w];
        e.data = {16'hB0B0, 10'h0, word[5:0]};
        eb[cyc + RLB] = e;
        e.data = {16'hC0C0, 10'h0, word[5:0]};
        ec[cyc + RLC] = e;
        ptr_b = (w + 1) % 3;
      end
      pend[w] = 1'b0;
    end
    e = '{ch: 0, err: 1'b0, rd: 1'b0, data: '0};
    if (n == 2) begin
      hit = ea.exists(cyc);
      if (hit) begin e = ea[cyc]; ea.delete(cyc); end
      chk_rsp("a", hit, e, {1'b0, a_rv}, {1'b0, a_err}, {32'h0, a_rd});
    end else begin
      hit = eb.exists(cyc);
      if (hit) begin e = eb[cyc]; eb.delete(cyc); end
      chk_rsp("b", hit, e, b_rv, b_err, b_rd);
      hit = ec.exists(cyc);
      if (hit) begin e = ec[cyc]; ec.delete(cyc); end
      chk_rsp("c", hit, e, c_rv, c_err, c_rd);
    end
    tick();
  endtask

  task automatic gen(input int n, input int pct);
    logic [31:0] base, a;
    int          maw, r;
    base = (n == 2) ? 32'h0 : BASE_B;
    maw  = (n == 2) ? 16 : 6;
    for (int k = 0; k < n; k++) begin
      if (!pend[k] && $urandom_range(0, 99) < pct) begin
        r = $urandom_range(0, 9);
        if (r == 0)               a = base + (32'd1 << (maw + 2)) + 32'($urandom_range(0, 255));
        else if (r == 1 && n == 3) a = base - 32'($urandom_range(1, 16));
        else                      a = base + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        put(k, a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      end
    end
  endtask

  task automatic chk_all_idle(input string t);
    chk({t, "_a_out"}, {a_gnt, a_rv, a_err, a_men, a_mwe, a_maddr, a_mwd, a_rd}, '0);
    chk({t, "_b_out"}, {b_gnt, b_rv, b_err, b_men, b_mwe, b_maddr, b_mwd}, '0);
    chk({t, "_b_rdata"}, b_rd, '0);
    chk({t, "_c_out"}, {c_gnt, c_rv, c_err, c_men, c_mwe, c_maddr, c_mwd}, '0);
    chk({t, "_c_rdata"}, c_rd, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) pend[k] = 1'b0;
    pack(2);
    repeat (3) @(negedge clk);
    #1;
    chk_all_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single read of a preloaded word, byte address 0x10 -> word 4.
    put(0, 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
    step(2);
    put(0, 32'h10, 1'b0, 4'h0, 32'h0);
    repeat (4) step(2);

    // Contention: both channels request every cycle.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) if (!pend[k]) put(k, 32'h10 + 32'(k * 4), 1'b0, 4'h0, 32'h0);
      step(2);
    end
    repeat (4) step(2);

    // Single-byte write merged into a known word, then read back.
    put(1, 32'h8, 1'b1, 4'hF, 32'hAABB_CCDD);
    step(2);
    put(1, 32'h8, 1'b1, 4'b0100, 32'h1122_3344);
    step(2);
    put(1, 32'h8, 1'b0, 4'h0, 32'h0);
    step(2);
    put(0, 32'h8, 1'b1, 4'h0, 32'hFFFF_FFFF);
    step(2);
    put(0, 32'h8, 1'b0, 4'h0, 32'h0);
    repeat (4) step(2);

    // Out-of-window read.
    put(0, 32'h0004_0000, 1'b0, 4'h0, 32'h0);
    repeat (4) step(2);

    // Reset with a read in flight and a request still pending.
    put(0, 32'h10, 1'b0, 4'h0, 32'h0);
    step(2);
    rst_n = 1'b0;
    put(1, 32'h14, 1'b0, 4'h0, 32'h0);
    pack(2);
    #1;
    chk_all_idle("rst_mid");
    tick();
    pend[1] = 1'b0;
    ea.delete();
    ptr_a = 0;
    pack(2);
    rst_n = 1'b1;
    put(0, 32'h10, 1'b0, 4'h0, 32'h0);
    put(1, 32'h14, 1'b0, 4'h0, 32'h0);
    repeat (6) step(2);

    repeat (300) begin
      gen(2, 60);
      step(2);
    end
    repeat (6) step(2);

    // Three-way rotation with all channels requesting continuously.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 3; k++) if (!pend[k]) put(k, BASE_B + 32'(k * 4), 1'b0, 4'h0, 32'h0);
      step(3);
    end
    repeat (5) step(3);

    // A lone request on each channel.
    for (int k = 0; k < 3; k++) begin
      put(k, BASE_B + 32'h20 + 32'(k * 4), 1'b0, 4'h0, 32'h0);
      repeat (4) step(3);
    end

    repeat (300) begin
      gen(3, 50);
      step(3);
    end
    repeat (8) step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
